// File: rtl/vote_mon_pkg.sv
// Shared types and default parameters for the vote run monitor.
package vote_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_ALARM   = 2'd2,
        S_HOLDOFF = 2'd3
    } state_e;

    localparam int DEF_RUN_W     = 8;
    localparam int DEF_ALARM_LEN = 4;
    localparam int DEF_HOLDOFF   = 2;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vote_run_monitor.sv
// Qualifies the majority-vote flag into rise/fall pulses, run lengths, an alarm
// and a saturating event count. Optional: VOTE_RUN_STICKY_ALARM_EN (sticky alarm).
module vote_run_monitor
    import vote_mon_pkg::*;
#(
    parameter int RUN_W     = DEF_RUN_W,
    parameter int ALARM_LEN = DEF_ALARM_LEN,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             vote_in,
    input  logic             clear_cnt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             alarm,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] last_run,
    output logic             last_run_valid,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             rise_q, fall_q, lrv_q, alarm_q;
    logic             alarm_d;
    logic [RUN_W-1:0] last_run_q;
    logic [RUN_W-1:0] run_len_inc;
    logic             start, run_end, alarm_entry, in_run;

    assign in_run      = (state_q == S_RUN) || (state_q == S_ALARM);
    assign run_len_inc = (run_len == '1) ? run_len : run_len + RUN_W'(1);

    // The run-ending sample is itself the first ignored hold-off sample, so the
    // counter holds the remaining HOLDOFF-1 samples to skip before IDLE.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        start   = 1'b0;
        run_end = 1'b0;
        if (sample_en) begin
            case (state_q)
                S_IDLE: begin
                    if (vote_in) begin
                        start   = 1'b1;
                        state_d = (ALARM_LEN == 1) ? S_ALARM : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!vote_in) begin
                        run_end = 1'b1;
                    end else if (run_len_inc >= RUN_W'(ALARM_LEN)) begin
                        state_d = S_ALARM;
                    end
                end
                S_ALARM: begin
                    if (!vote_in) run_end = 1'b1;
                end
                default: begin
                    hold_d = hold_q - HW'(1);
                    if (hold_q <= HW'(1)) state_d = S_IDLE;
                end
            endcase
            if (run_end) begin
                if (HOLDOFF > 1) begin
                    state_d = S_HOLDOFF;
                    hold_d  = HW'(HOLDOFF - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    assign alarm_entry = (state_d == S_ALARM) && (state_q != S_ALARM);

`ifdef VOTE_RUN_STICKY_ALARM_EN
    assign alarm_d = alarm_entry | (alarm_q & ~clear_cnt);
`else
    assign alarm_d = (state_d == S_ALARM);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            lrv_q      <= 1'b0;
            alarm_q    <= 1'b0;
            last_run_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rise_q  <= start;
            fall_q  <= run_end;
            lrv_q   <= run_end;
            alarm_q <= alarm_d;
            if (run_end) last_run_q <= run_len;
        end
    end

    sat_counter #(.W(RUN_W)) u_run_len (
        .clk   (clk),
        .reset (reset),
        .en_i  (sample_en),
        .inc_i (start | (in_run & vote_in)),
        .clr_i (run_end),
        .cnt_o (run_len)
    );

    sat_counter #(.W(CNT_W)) u_event_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .inc_i (start),
        .clr_i (clear_cnt),
        .cnt_o (event_cnt)
    );

    assign rise_pulse     = rise_q;
    assign fall_pulse     = fall_q;
    assign last_run_valid = lrv_q;
    assign alarm          = alarm_q;
    assign last_run       = last_run_q;

endmodule

// File: tb/tb_vote_run_monitor.sv
// Directed bench for vote_run_monitor: default instance plus a CNT_W=2, HOLDOFF=0 instance.
module tb_vote_run_monitor;

`ifdef VOTE_RUN_STICKY_ALARM_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic clk, reset, sample_en, vote_in, clear_cnt;
    logic rise_a, fall_a, alarm_a, lrv_a;
    logic [7:0] run_len_a, last_run_a;
    logic [15:0] cnt_a;
    logic rise_b, fall_b, alarm_b, lrv_b;
    logic [7:0] run_len_b, last_run_b;
    logic [1:0] cnt_b;
    int checks = 0;
    int errors = 0;

    vote_run_monitor dut_a (
        .clk(clk), .reset(reset), .sample_en(sample_en), .vote_in(vote_in),
        .clear_cnt(clear_cnt), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .alarm(alarm_a), .run_len(run_len_a), .last_run(last_run_a),
        .last_run_valid(lrv_a), .event_cnt(cnt_a)
    );

    vote_run_monitor #(.CNT_W(2), .HOLDOFF(0)) dut_b (
        .clk(clk), .reset(reset), .sample_en(sample_en), .vote_in(vote_in),
        .clear_cnt(clear_cnt), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .alarm(alarm_b), .run_len(run_len_b), .last_run(last_run_b),
        .last_run_valid(lrv_b), .event_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic en, input logic v, input logic clr);
        sample_en = en;
        vote_in   = v;
        clear_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_en = 1'b0;
        vote_in = 1'b0;
        clear_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rise_a, fall_a, alarm_a, lrv_a, run_len_a, last_run_a, cnt_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got r%0b f%0b a%0b v%0b rl%0d lr%0d ec%0d exp all 0",
                     rise_a, fall_a, alarm_a, lrv_a, run_len_a, last_run_a, cnt_a);
        end
    endtask

    task automatic test_basic();
        logic [6:0] vs, rs, fs;
        vs = 7'b1000110;
        rs = 7'b1000010;
        fs = 7'b0001000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vs[i], 1'b0);
            checks++;
            if ({rise_a, fall_a, lrv_a, alarm_a} !== {rs[i], fs[i], fs[i], 1'b0}) begin
                errors++;
                $display("FAIL basic_pulses cyc%0d got r%0b f%0b v%0b a%0b exp r%0b f%0b v%0b a0",
                         i + 1, rise_a, fall_a, lrv_a, alarm_a, rs[i], fs[i], fs[i]);
            end
            if (i == 3) begin
                checks++;
                if (last_run_a !== 8'd2) begin
                    errors++;
                    $display("FAIL basic_last_run got %0d exp 2", last_run_a);
                end
            end
        end
        checks++;
        if (cnt_a !== 16'd2) begin
            errors++;
            $display("FAIL basic_event_cnt got %0d exp 2", cnt_a);
        end
    endtask

    task automatic test_alarm();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (run_len_a !== 8'(k) || alarm_a !== (k >= 4)) begin
                errors++;
                $display("FAIL alarm_run k%0d got rl%0d a%0b exp rl%0d a%0b",
                         k, run_len_a, alarm_a, k, (k >= 4));
            end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if ({fall_a, lrv_a, last_run_a, run_len_a, alarm_a} !== {1'b1, 1'b1, 8'd6, 8'd0, STICKY}) begin
            errors++;
            $display("FAIL alarm_fall got f%0b v%0b lr%0d rl%0d a%0b exp f1 v1 lr6 rl0 a%0b",
                     fall_a, lrv_a, last_run_a, run_len_a, alarm_a, STICKY);
        end
    endtask

    task automatic test_holdoff();
        logic [4:0] vs, rs;
        vs = 5'b11101;
        rs = 5'b01001;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vs[i], 1'b0);
            checks++;
            if (rise_a !== rs[i]) begin
                errors++;
                $display("FAIL holdoff_rise s%0d got %0b exp %0b", i + 1, rise_a, rs[i]);
            end
        end
        checks++;
        if (cnt_a !== 16'd2 || run_len_a !== 8'd2) begin
            errors++;
            $display("FAIL holdoff_end got ec%0d rl%0d exp ec2 rl2", cnt_a, run_len_a);
        end
    endtask

    task automatic test_enable();
        logic [3:0] en;
        logic [7:0] exp_rl [4];
        en = 4'b0101;
        exp_rl = '{8'd1, 8'd1, 8'd2, 8'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(en[i], 1'b1, 1'b0);
            checks++;
            if (run_len_a !== exp_rl[i] || rise_a !== (i == 0) || fall_a !== 1'b0) begin
                errors++;
                $display("FAIL enable c%0d got rl%0d r%0b f%0b exp rl%0d r%0b f0",
                         i, run_len_a, rise_a, fall_a, exp_rl[i], (i == 0));
            end
        end
    endtask

    task automatic test_sat_cnt();
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (cnt_b !== 2'((e > 3) ? 3 : e)) begin
                errors++;
                $display("FAIL satcnt ev%0d got %0d exp %0d", e, cnt_b, (e > 3) ? 3 : e);
            end
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (cnt_b !== 2'd0 || rise_b !== 1'b1) begin
            errors++;
            $display("FAIL satcnt_clear got ec%0d r%0b exp ec0 r1", cnt_b, rise_b);
        end
    endtask

    task automatic test_run_sat();
        do_reset();
        repeat (260) step(1'b1, 1'b1, 1'b0);
        checks++;
        if (run_len_a !== 8'd255 || alarm_a !== 1'b1) begin
            errors++;
            $display("FAIL runsat_len got rl%0d a%0b exp rl255 a1", run_len_a, alarm_a);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (last_run_a !== 8'd255 || lrv_a !== 1'b1) begin
            errors++;
            $display("FAIL runsat_last got lr%0d v%0b exp lr255 v1", last_run_a, lrv_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) step(1'b1, 1'b1, 1'b0);
        checks++;
        if (run_len_a !== 8'd5 || alarm_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got rl%0d a%0b exp rl5 a1", run_len_a, alarm_a);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rise_a, fall_a, alarm_a, lrv_a, run_len_a, last_run_a, cnt_a} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got f%0b a%0b rl%0d ec%0d exp all 0",
                     fall_a, alarm_a, run_len_a, cnt_a);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (fall_a !== 1'b0 || run_len_a !== 8'd0) begin
            errors++;
            $display("FAIL midreset_nofall got f%0b rl%0d exp f0 rl0", fall_a, run_len_a);
        end
    endtask

    task automatic test_sticky();
        do_reset();
        repeat (4) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (fall_a !== 1'b1 || alarm_a !== STICKY) begin
            errors++;
            $display("FAIL sticky_fall got f%0b a%0b exp f1 a%0b", fall_a, alarm_a, STICKY);
        end
        repeat (2) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (alarm_a !== STICKY) begin
            errors++;
            $display("FAIL sticky_idle got a%0b exp a%0b", alarm_a, STICKY);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (alarm_a !== 1'b0 || cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL sticky_clear got a%0b ec%0d exp a0 ec0", alarm_a, cnt_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_en = 1'b0;
        vote_in = 1'b0;
        clear_cnt = 1'b0;
        test_reset();
        test_basic();
        test_alarm();
        test_holdoff();
        test_enable();
        test_sat_cnt();
        test_run_sat();
        test_reset_mid();
        test_sticky();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_run_monitor.md
Name: vote_run_monitor

Overview:
Downstream consumer of the 3-sample majority vote flag, the 1-bit "2 or more of the last 3 samples are 1" output.
- Qualifies the vote into discrete events: rise/fall pulses, run-length measurement, a long-run alarm, and a saturating event counter.
- Applies a post-event hold-off so vote chatter does not generate spurious events.
- Feeds status/interrupt logic.

Parameters:
RUN_W, 8, width of run-length counters; run length saturates at 2^RUN_W-1
ALARM_LEN, 4, consecutive high samples needed to raise alarm; legal range 1..2^RUN_W-1
HOLDOFF, 2, samples ignored after a run ends; 0 = no hold-off
CNT_W, 16, width of event counter; saturates at 2^CNT_W-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
sample_en  in  1  qualifies vote_in; the FSM and counters advance only when this is 1
vote_in  in  1  majority vote flag from the upstream detector
clear_cnt  in  1  synchronous clear of event_cnt (and of sticky alarm, if enabled)
rise_pulse  out  1  one-cycle pulse when a new run starts
fall_pulse  out  1  one-cycle pulse when a run ends
alarm  out  1  high while the current run is at least ALARM_LEN samples
run_len  out  RUN_W  length of the current run so far; 0 when not in a run
last_run  out  RUN_W  length of the most recently completed run
last_run_valid  out  1  one-cycle pulse; last_run updated this cycle
event_cnt  out  CNT_W  number of runs started, saturating

Behaviour:
- Reset: state=IDLE, all outputs 0, hold-off counter 0.
- Registers and outputs:
  - All outputs are registered.
  - A sample taken at edge k is reflected in the outputs immediately after edge k.
  - Pulses last exactly 1 clk and are 0 in any cycle without an event.
  - With sample_en=0: state, run_len, hold-off counter and alarm hold their values; pulses are 0.
- State IDLE:
  - vote=0: stay in IDLE.
  - vote=1: go to RUN with run_len=1, rise_pulse=1, event_cnt+1 (saturating).
  - If ALARM_LEN==1, go to ALARM directly with alarm=1.
- State RUN:
  - vote=1: run_len+1, saturating at max.
  - When the new run_len reaches ALARM_LEN: go to ALARM, alarm=1.
- State ALARM:
  - vote=1: run_len+1, saturating; stay in ALARM.
- Run end (RUN or ALARM with vote=0):
  - last_run<=run_len, last_run_valid=1, fall_pulse=1, run_len<=0, alarm<=0.
  - If HOLDOFF>0: go to HOLDOFF with the hold-off counter loaded to HOLDOFF. Otherwise go to IDLE.
- State HOLDOFF:
  - vote ignored.
  - Counter decrements once per qualified sample; on the sample where it reaches 0, go to IDLE.
  - A vote=1 on the first IDLE sample starts a new run.
- Saturation: run_len saturates and the run continues; last_run reports the saturated value.
- event_cnt saturates at all-ones and no longer increments.
- clear_cnt:
  - Acts regardless of sample_en.
  - Takes priority over a coincident increment: event_cnt=0 and the coincident event is not counted.
  - Does not affect the FSM, run_len or last_run.
- Reset mid-run: all state is discarded immediately; no fall_pulse is issued.

Optional Feature:
VOTE_RUN_STICKY_ALARM_EN
- Defined: alarm is set on entry to ALARM and stays 1 through the run end and later IDLE/RUN periods until clear_cnt=1 or reset. If clear_cnt and an alarm entry coincide, the alarm entry wins and alarm stays 1.
- Undefined: alarm follows the ALARM state as described above.

Decomposition:
Package vote_mon_pkg holds:
- State typedef: IDLE, RUN, ALARM, HOLDOFF; 2-bit encoding.
- Default parameter constants.

Sub-module sat_counter:
- Parameterised width; inputs inc, clr, en; clr has priority.
- Instantiated for run_len and for event_cnt.
- The hold-off counter stays inline.

Test Plan:
1. Defaults, sample_en=1, vote 0,1,1,0,0,0,1:
   - rise_pulse in cycles 2 and 7; fall_pulse and last_run_valid in cycle 4 with last_run=2.
   - alarm never set; event_cnt=2.
2. vote held 1 for 6 samples:
   - alarm rises on the 4th sample and stays high.
   - run_len 1..6; at the fall, last_run=6 and alarm drops.
3. Hold-off: vote 1,0,1,1,1 with HOLDOFF=2:
   - The 2nd and 3rd samples (vote 0, then vote 1) are ignored.
   - The new run starts on the 4th sample; event_cnt=2.
4. sample_en toggling 1,0,1,0 with vote=1:
   - run_len advances only on the enabled cycles, reaching 2.
   - Pulses never appear in disabled cycles.
5. CNT_W=2, run 5 separate events: event_cnt reads 3 after the 3rd, 4th and 5th events. Then assert clear_cnt in the same cycle as a rise: event_cnt=0.
6. Assert reset during ALARM with run_len=5: all outputs are 0 on the next cycle, no fall_pulse. With VOTE_RUN_STICKY_ALARM_EN defined, in a separate run: alarm stays 1 after the fall until clear_cnt is asserted.
